// File: rtl/sys_trap_ctrl.sv
// Machine-mode trap sequencer: interrupt/exception arbitration, pipeline drain, mepc/mcause save, mtvec redirect, mret.
// Optional vectored interrupt dispatch is enabled by defining SYS_TRAP_VECTORED_EN.
module sys_trap_ctrl #(
    parameter int XLEN      = 32,
    parameter int DRAIN_MAX = 63
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ext_irq,
    input  logic            exc_vld,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            mret_vld,
    input  logic [XLEN-1:0] int_pc,
    input  logic            pipe_empty,
    input  logic [63:0]     mtime,
    input  logic            csr_wr,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            hold_fetch,
    output logic            mepc_wr,
    output logic [XLEN-1:0] mepc_data,
    output logic [XLEN-1:0] mcause_data,
    output logic            jump_vld,
    output logic [XLEN-1:0] jump_pc
);
    localparam int CW = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, SAVE, JUMP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            mie_bit;
    logic            mpie_bit;
    logic            meie;
    logic            mtie;
    logic            msie;
    logic            msip;
    logic [63:0]     mtimecmp;
    logic [XLEN-1:0] mtvec;
    logic            timer_hit;
    logic            pend_ext;
    logic            pend_sw;
    logic            pend_tmr;
    logic            pend;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] trap_target;

    assign timer_hit = (mtime >= mtimecmp);
    assign pend_ext  = meie & ext_irq;
    assign pend_sw   = msie & msip;
    assign pend_tmr  = mtie & timer_hit;
    assign pend      = mie_bit & (pend_ext | pend_sw | pend_tmr);
    assign cnt_nxt   = cnt + CW'(1);

    always_comb begin
        irq_code = 4'd7;
        if (pend_ext)
            irq_code = 4'd11;
        else if (pend_sw)
            irq_code = 4'd3;
    end

    // mcause_data already holds the cause of the trap being taken when SAVE computes the target.
    always_comb begin
        trap_target = {mtvec[XLEN-1:2], 2'b00};
`ifdef SYS_TRAP_VECTORED_EN
        if (mtvec[1:0] == 2'b01 && mcause_data[XLEN-1])
            trap_target = trap_target + XLEN'({mcause_data[3:0], 2'b00});
`endif
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            12'h300: begin
                csr_rdata[3] = mie_bit;
                csr_rdata[7] = mpie_bit;
            end
            12'h304: begin
                csr_rdata[3]  = msie;
                csr_rdata[7]  = mtie;
                csr_rdata[11] = meie;
            end
            12'h344: begin
                csr_rdata[3]  = msip;
                csr_rdata[7]  = timer_hit;
                csr_rdata[11] = ext_irq;
            end
            12'h305: csr_rdata = mtvec;
            12'h7C0: csr_rdata = XLEN'(mtimecmp[31:0]);
            12'h7C1: csr_rdata = XLEN'(mtimecmp[63:32]);
            default: csr_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mie_bit     <= 1'b0;
            mpie_bit    <= 1'b0;
            meie        <= 1'b0;
            mtie        <= 1'b0;
            msie        <= 1'b0;
            msip        <= 1'b0;
            mtimecmp    <= '1;
            mtvec       <= '0;
            hold_fetch  <= 1'b0;
            mepc_wr     <= 1'b0;
            mepc_data   <= '0;
            mcause_data <= '0;
            jump_vld    <= 1'b0;
            jump_pc     <= '0;
        end else begin
            mepc_wr  <= 1'b0;
            jump_vld <= 1'b0;

            if (csr_wr) begin
                case (csr_addr)
                    12'h300: begin
                        mie_bit  <= csr_wdata[3];
                        mpie_bit <= csr_wdata[7];
                    end
                    12'h304: begin
                        msie <= csr_wdata[3];
                        mtie <= csr_wdata[7];
                        meie <= csr_wdata[11];
                    end
                    12'h344: msip <= csr_wdata[3];
`ifdef SYS_TRAP_VECTORED_EN
                    12'h305: mtvec <= {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0]};
`else
                    12'h305: mtvec <= {csr_wdata[XLEN-1:2], 2'b00};
`endif
                    12'h7C0: mtimecmp[31:0]  <= csr_wdata[31:0];
                    12'h7C1: mtimecmp[63:32] <= csr_wdata[31:0];
                    default: ;
                endcase
            end

            // FSM updates to MIE/MPIE come after the CSR write so they take precedence.
            case (state)
                IDLE: begin
                    if (exc_vld) begin
                        mcause_data <= {{(XLEN-4){1'b0}}, exc_cause};
                        mepc_data   <= exc_pc;
                        mepc_wr     <= 1'b1;
                        hold_fetch  <= 1'b1;
                        state       <= SAVE;
                    end else if (pend) begin
                        cnt        <= '0;
                        hold_fetch <= 1'b1;
                        state      <= DRAIN;
                    end else if (mret_vld) begin
                        mie_bit  <= mpie_bit;
                        mpie_bit <= 1'b1;
                        jump_vld <= 1'b1;
                        jump_pc  <= {mepc_data[XLEN-1:2], 2'b00};
                    end
                end
                DRAIN: begin
                    cnt <= cnt_nxt;
                    if (exc_vld) begin
                        mcause_data <= {{(XLEN-4){1'b0}}, exc_cause};
                        mepc_data   <= exc_pc;
                        mepc_wr     <= 1'b1;
                        state       <= SAVE;
                    end else if (!pend) begin
                        hold_fetch <= 1'b0;
                        state      <= IDLE;
                    end else if (pipe_empty || cnt_nxt == CW'(DRAIN_MAX)) begin
                        mcause_data <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
                        mepc_data   <= int_pc;
                        mepc_wr     <= 1'b1;
                        state       <= SAVE;
                    end
                end
                SAVE: begin
                    mpie_bit   <= mie_bit;
                    mie_bit    <= 1'b0;
                    jump_vld   <= 1'b1;
                    jump_pc    <= trap_target;
                    hold_fetch <= 1'b0;
                    state      <= JUMP;
                end
                JUMP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
